// File: rtl/pulse_meas_pkg.sv
// Shared types and constants for the pulse_meas block.
// The optional idle-edge timeout is enabled by defining PULSE_MEAS_TIMEOUT_EN.
package pulse_meas_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_R = 3'd1,
        HIGH   = 3'd2,
        LOW    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int TIMEOUT_DEF = 1_000_000;

    // Saturation ceiling for a w-bit unsigned counter.
    function automatic logic [63:0] cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/pm_sync_edge.sv
// Synchronizer for an asynchronous input followed by a registered edge detector.
// lvl, rise and fall are mutually aligned and lag the input by SYNC_STG+1 clocks.
module pm_sync_edge #(
    parameter int SYNC_STG = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);
    logic [SYNC_STG-1:0] r_sync;
    logic                r_prev;
    logic                r_rise;
    logic                r_fall;
    logic                w_sync;

    assign w_sync = r_sync[SYNC_STG-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_d};
            r_prev <= w_sync;
            r_rise <= w_sync & ~r_prev;
            r_fall <= ~w_sync & r_prev;
        end
    end

    assign o_lvl  = r_prev;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/pulse_meas.sv
// Measures one high time and one rise-to-rise period of pulse_i, reported with valid/ack.
// Define PULSE_MEAS_TIMEOUT_EN to end a stalled measurement after TIMEOUT edge-free clocks.
module pulse_meas
    import pulse_meas_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int SYNC_STG = 2,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             pulse_i,
    input  logic             arm_i,
    input  logic             ack_i,
    output logic [CNT_W-1:0] high_cnt_o,
    output logic [CNT_W-1:0] period_cnt_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             ovf_o,
    output logic             timeout_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    if (!(SYNC_STG == 2 || SYNC_STG == 3) || TIMEOUT < 1) begin : g_param_chk
        $error("pulse_meas: SYNC_STG must be 2 or 3 and TIMEOUT positive");
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_period;
    logic             r_valid;
    logic             r_ovf;
    logic             w_lvl;
    logic             w_rise;
    logic             w_fall;
    logic             w_busy;
    logic             w_hsat;
    logic             w_psat;
    logic [CNT_W-1:0] w_hinc;
    logic [CNT_W-1:0] w_pinc;

    pm_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync (
        .i_clk  (wb_clk_i),
        .i_rst  (wb_rst_i),
        .i_d    (pulse_i),
        .o_lvl  (w_lvl),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_busy = (r_state == WAIT_R) || (r_state == HIGH) || (r_state == LOW);
    assign w_hsat = (r_hcnt == CNT_MAX);
    assign w_psat = (r_pcnt == CNT_MAX);
    assign w_hinc = w_hsat ? r_hcnt : r_hcnt + CNT_W'(1);
    assign w_pinc = w_psat ? r_pcnt : r_pcnt + CNT_W'(1);

`ifdef PULSE_MEAS_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] r_tmr;
    logic             r_tmo;
    logic             w_tmo_hit;

    assign w_tmo_hit = (r_tmr == TMR_W'(TIMEOUT));

    // Clocks since arming or since the last synchronized edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)
            r_tmr <= '0;
        else if (!w_busy || w_rise || w_fall)
            r_tmr <= '0;
        else
            r_tmr <= r_tmr + TMR_W'(1);
    end

    assign timeout_o = r_tmo;
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= IDLE;
            r_hcnt   <= '0;
            r_pcnt   <= '0;
            r_high   <= '0;
            r_period <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef PULSE_MEAS_TIMEOUT_EN
            r_tmo    <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (arm_i) begin
                        r_state  <= WAIT_R;
                        r_hcnt   <= '0;
                        r_pcnt   <= '0;
                        r_high   <= '0;
                        r_period <= '0;
                        r_ovf    <= 1'b0;
`ifdef PULSE_MEAS_TIMEOUT_EN
                        r_tmo    <= 1'b0;
`endif
                    end
                end
                WAIT_R, HIGH, LOW: begin
                    if (!arm_i) begin
                        r_state <= IDLE;
`ifdef PULSE_MEAS_TIMEOUT_EN
                    end else if (w_tmo_hit) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                        r_tmo   <= 1'b1;
`endif
                    end else if (r_state == WAIT_R) begin
                        if (w_rise) begin
                            r_state <= HIGH;
                            r_hcnt  <= CNT_W'(1);
                            r_pcnt  <= CNT_W'(1);
                        end
                    end else if (r_state == HIGH) begin
                        // lvl is already low on the fall cycle, so hcnt stops there.
                        r_pcnt <= w_pinc;
                        if (w_fall) begin
                            r_state <= LOW;
                            r_high  <= r_hcnt;
                            r_ovf   <= r_ovf | w_psat;
                        end else if (w_lvl) begin
                            r_hcnt <= w_hinc;
                            r_ovf  <= r_ovf | w_psat | w_hsat;
                        end else begin
                            r_ovf  <= r_ovf | w_psat;
                        end
                    end else begin
                        if (w_rise) begin
                            r_state  <= DONE;
                            r_period <= r_pcnt;
                            r_valid  <= 1'b1;
                        end else begin
                            r_pcnt <= w_pinc;
                            r_ovf  <= r_ovf | w_psat;
                        end
                    end
                end
                DONE: begin
                    if (ack_i) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign high_cnt_o   = r_high;
    assign period_cnt_o = r_period;
    assign valid_o      = r_valid;
    assign busy_o       = w_busy;
    assign ovf_o        = r_ovf;

endmodule

// File: tb/tb_pulse_meas.sv
// Directed bench for pulse_meas: two instances (32-bit and 4-bit counters) against a
// timestamp-based reference model, plus hand-computed literal expectations.
module tb_pulse_meas;
    localparam int S   = 2;
    localparam int TMO = 50;
`ifdef PULSE_MEAS_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, pulse = 1'b0, arm = 1'b0, ack = 1'b0;
    logic [31:0] hi32, per32;
    logic [3:0]  hi4, per4;
    logic v32, b32, o32, t32, v4, b4, o4, t4;
    int chk = 0, err = 0;

    always #5 clk = ~clk;

    pulse_meas #(.CNT_W(32), .SYNC_STG(S), .TIMEOUT(TMO)) dut32 (
        .wb_clk_i(clk), .wb_rst_i(rst), .pulse_i(pulse), .arm_i(arm), .ack_i(ack),
        .high_cnt_o(hi32), .period_cnt_o(per32), .valid_o(v32), .busy_o(b32),
        .ovf_o(o32), .timeout_o(t32));

    pulse_meas #(.CNT_W(4), .SYNC_STG(S), .TIMEOUT(TMO)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .pulse_i(pulse), .arm_i(arm), .ack_i(ack),
        .high_cnt_o(hi4), .period_cnt_o(per4), .valid_o(v4), .busy_o(b4),
        .ovf_o(o4), .timeout_o(t4));

    // Model: phase 0 idle, 1 armed, 2 high, 3 low, 4 result held.
    // Results are differences of edge timestamps, clipped at the counter ceiling.
    typedef struct {
        int     ph;
        longint trise;
        longint tev;
        longint hi;
        longint per;
        bit     valid;
        bit     ovf;
        bit     tmo;
    } mst_t;

    mst_t       m32 = '{default: 0};
    mst_t       m4  = '{default: 0};
    longint     cyc = 0;
    logic [7:0] hist = '0;

    function automatic mst_t mstep(mst_t s, longint k, bit a, bit ak, bit r, bit f, longint mx);
        mst_t   n = s;
        longint d = k - s.trise;
        case (s.ph)
            0: if (a) begin
                n.ph = 1; n.hi = 0; n.per = 0; n.ovf = 0; n.tmo = 0; n.tev = k;
            end
            1, 2, 3: begin
                if (!a) n.ph = 0;
                else if (TMO_ON && (k - s.tev > TMO)) begin
                    n.ph = 4; n.valid = 1; n.tmo = 1;
                end else begin
                    if (r || f) n.tev = k;
                    if (s.ph == 1 && r) begin
                        n.ph = 2; n.trise = k;
                    end else if (s.ph == 2 && f) begin
                        n.ph = 3; n.hi = (d > mx) ? mx : d; n.ovf = s.ovf | (d > mx);
                    end else if (s.ph == 3 && r) begin
                        n.ph = 4; n.per = (d > mx) ? mx : d; n.ovf = s.ovf | (d > mx);
                        n.valid = 1;
                    end
                end
            end
            default: if (ak) begin
                n.ph = 0; n.valid = 0;
            end
        endcase
        return n;
    endfunction

    // hist[j] is pulse_i as sampled j+1 edges ago; strobes reach the FSM S+1 edges late.
    always @(posedge clk) begin
        if (rst) begin
            m32  <= '{default: 0};
            m4   <= '{default: 0};
            hist <= '0;
        end else begin
            m32  <= mstep(m32, cyc, arm, ack, hist[S] & ~hist[S+1], ~hist[S] & hist[S+1], 64'hFFFF_FFFF);
            m4   <= mstep(m4,  cyc, arm, ack, hist[S] & ~hist[S+1], ~hist[S] & hist[S+1], 64'd15);
            hist <= {hist[6:0], pulse};
        end
        cyc <= cyc + 1;
    end

    task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic compare();
        ck("busy32",  64'(b32),   64'(m32.ph >= 1 && m32.ph <= 3));
        ck("valid32", 64'(v32),   64'(m32.valid));
        ck("high32",  64'(hi32),  64'(m32.hi));
        ck("per32",   64'(per32), 64'(m32.per));
        ck("tmo32",   64'(t32),   64'(m32.tmo));
        ck("busy4",   64'(b4),    64'(m4.ph >= 1 && m4.ph <= 3));
        ck("valid4",  64'(v4),    64'(m4.valid));
        ck("high4",   64'(hi4),   64'(m4.hi));
        ck("per4",    64'(per4),  64'(m4.per));
        ck("tmo4",    64'(t4),    64'(m4.tmo));
        if (m32.valid) ck("ovf32", 64'(o32), 64'(m32.ovf));
        if (m4.valid)  ck("ovf4",  64'(o4),  64'(m4.ovf));
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            compare();
        end
    endtask

    task automatic train(input int h, input int l, input int reps);
        repeat (reps) begin
            pulse = 1'b1; tick(h);
            pulse = 1'b0; tick(l);
        end
    endtask

    initial begin
        // Reset held 3 clocks with pulse toggling
        repeat (3) begin pulse = ~pulse; tick(1); end
        ck("rst_high",  64'(hi32),  0);
        ck("rst_per",   64'(per32), 0);
        ck("rst_valid", 64'({v32, b32, o32, t32, v4, b4, o4, t4}), 0);
        rst = 1'b0;
        repeat (6) begin pulse = ~pulse; tick(1); end
        ck("unarmed_busy", 64'({b32, v32}), 0);

        // Basic 3 high / 7 low
        pulse = 1'b0; tick(4);
        arm = 1'b1; tick(1);
        train(3, 7, 3);
        ck("basic_high",  64'(hi32),  3);
        ck("basic_per",   64'(per32), 10);
        ck("basic_valid", 64'(v32),   1);
        ck("basic_ovf",   64'(o32),   0);
        ck("basic_high4", 64'(hi4),   3);
        tick(3);
        ack = 1'b1; tick(1); ack = 1'b0;
        ck("ack_clears_valid", 64'(v32), 0);
        arm = 1'b0; tick(2);

        // Abort two clocks into HIGH, then re-arm
        arm = 1'b1; tick(2);
        pulse = 1'b1; tick(4);
        tick(2);
        arm = 1'b0; tick(1);
        ck("abort_busy",  64'(b32), 0);
        ck("abort_valid", 64'(v32), 0);
        tick(3);
        pulse = 1'b0; tick(5);
        arm = 1'b1; tick(1);
        train(3, 7, 2);
        ck("rearm_high", 64'(hi32),  3);
        ck("rearm_per",  64'(per32), 10);
        ack = 1'b1; tick(1); ack = 1'b0;
        arm = 1'b0; tick(2);

        // Saturation: high 20, period 30
        arm = 1'b1; tick(2);
        pulse = 1'b1; tick(20);
        pulse = 1'b0; tick(10);
        pulse = 1'b1; tick(5);
        ck("sat_high4",  64'(hi4),   15);
        ck("sat_per4",   64'(per4),  15);
        ck("sat_ovf4",   64'(o4),    1);
        ck("sat_valid4", 64'(v4),    1);
        ck("wide_high",  64'(hi32),  20);
        ck("wide_per",   64'(per32), 30);
        ck("wide_ovf",   64'(o32),   0);
        ack = 1'b1; tick(1); ack = 1'b0;
        arm = 1'b0; pulse = 1'b0; tick(5);

        // ack and arm together in DONE
        arm = 1'b1; tick(1);
        train(3, 7, 2);
        ck("coll_valid_before", 64'(v32), 1);
        ack = 1'b1; tick(1); ack = 1'b0;
        ck("coll_idle_busy",  64'(b32), 0);
        ck("coll_idle_valid", 64'(v32), 0);
        tick(1);
        ck("coll_rearm_busy", 64'(b32), 1);
        arm = 1'b0; tick(2);

`ifdef PULSE_MEAS_TIMEOUT_EN
        // Stuck-low input after arming
        pulse = 1'b0; tick(4);
        arm = 1'b1; tick(1);
        tick(50);
        ck("tmo_not_yet", 64'(v32), 0);
        tick(1);
        ck("tmo_valid", 64'(v32),   1);
        ck("tmo_flag",  64'(t32),   1);
        ck("tmo_high",  64'(hi32),  0);
        ck("tmo_per",   64'(per32), 0);
        ack = 1'b1; tick(1); ack = 1'b0;
        arm = 1'b0; tick(2);
`endif

        // Reset in the middle of a measurement
        arm = 1'b1; tick(2);
        pulse = 1'b1; tick(6);
        rst = 1'b1; tick(2);
        ck("midrst_out", 64'({v32, b32, o32, t32}), 0);
        ck("midrst_high", 64'(hi32), 0);
        rst = 1'b0; arm = 1'b0; pulse = 1'b0; tick(20);
        ck("midrst_no_valid", 64'(v32), 0);

        $display("TB_RESULT checks=%0d failures=%0d", chk, err);
        $finish;
    end

endmodule
